// File: rtl/mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_scheduler
// Purpose  : Round controller for the keypad whack-a-LED game. Sequences
//            IDLE -> RUN -> FINAL -> IDLE and owns the target LED pattern,
//            the seconds countdown, the score/goal compare and the
//            end-of-game flashing phase.
// Ports    : clk, out_rst (async, active-high)
//            start_i, tick_i, key_valid_i : one-cycle pulses
//            cfg_time_i, cfg_goal_i       : game length / required hits
//            key_idx_i                    : decoded key (0..9 digits)
//            led_o, score_o, time_left_o, phase_o, win_o : registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module mole_round_scheduler #(
    parameter int          REFRESH_TICKS = 2,
    parameter int          FINAL_TICKS   = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        out_rst,
    input  logic        start_i,
    input  logic        tick_i,
    input  logic [7:0]  cfg_time_i,
    input  logic [7:0]  cfg_goal_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_idx_i,
    output logic [15:0] led_o,
    output logic [7:0]  score_o,
    output logic [7:0]  time_left_o,
    output logic [1:0]  phase_o,
    output logic        win_o
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_RUN   = 2'd1;
    localparam logic [1:0]  c_FINAL = 2'd2;

    // Counters compare against "last tick" so they never need a wider range.
    localparam logic [3:0]  c_REFRESH_LAST = 4'(REFRESH_TICKS - 1);
    localparam logic [3:0]  c_FINAL_LAST   = 4'(FINAL_TICKS - 1);
    localparam logic [7:0]  c_SCORE_MAX    = 8'd99;

    logic [1:0]  state_q, state_d;
    logic [15:0] led_q, led_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  time_q, time_d;
    logic [7:0]  goal_q, goal_d;
    logic        win_q, win_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [3:0]  fcnt_q, fcnt_d;

    logic [15:0] w_lfsr_next;
    logic [15:0] w_pattern;
    logic [3:0]  w_key_bit;
    logic        w_hit;
    logic        w_goal_met;
    logic        w_time_out;

    // Galois step; the pattern keeps only the ten keyable LEDs and is forced
    // nonzero so every round has at least one target.
    assign w_lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign w_pattern   = (w_lfsr_next[15:6] == 10'd0) ? 16'h8000
                                                      : {w_lfsr_next[15:6], 6'b0};

    assign w_key_bit  = 4'd15 - key_idx_i;
    assign w_hit      = key_valid_i && (key_idx_i <= 4'd9) && led_q[w_key_bit];
    // Exit is decided on registered values, so the transition lands one edge
    // after the update that created it.
    assign w_goal_met = (score_q == goal_q);
    assign w_time_out = (time_q == 8'd0);

    // State and datapath registers
    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            state_q <= c_IDLE;
            led_q   <= 16'h0000;
            score_q <= 8'd0;
            time_q  <= 8'd0;
            goal_q  <= 8'd0;
            win_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            rcnt_q  <= 4'd0;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            score_q <= score_d;
            time_q  <= time_d;
            goal_q  <= goal_d;
            win_q   <= win_d;
            lfsr_q  <= lfsr_d;
            rcnt_q  <= rcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start_i) state_d = c_RUN;
            c_RUN:   if (w_goal_met || w_time_out) state_d = c_FINAL;
            c_FINAL: if (tick_i && (fcnt_q == c_FINAL_LAST)) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        led_d   = led_q;
        score_d = score_q;
        time_d  = time_q;
        goal_d  = goal_q;
        win_d   = win_q;
        lfsr_d  = lfsr_q;
        rcnt_d  = rcnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            c_IDLE: begin
                led_d = 16'h0000;
                if (start_i) begin
                    time_d  = (cfg_time_i == 8'd0) ? 8'd1 : cfg_time_i;
                    goal_d  = (cfg_goal_i == 8'd0) ? 8'd1 : cfg_goal_i;
                    score_d = 8'd0;
                    win_d   = 1'b0;
                    lfsr_d  = w_lfsr_next;
                    led_d   = w_pattern;
                    rcnt_d  = 4'd0;
                end
            end
            c_RUN: begin
                if (w_hit) begin
                    led_d[w_key_bit] = 1'b0;
                    if (score_q != c_SCORE_MAX) score_d = score_q + 8'd1;
                end
                if (tick_i) begin
                    if (time_q != 8'd0) time_d = time_q - 8'd1;
                    if (rcnt_q == c_REFRESH_LAST) begin
                        // Refresh load wins over the hit-clear above.
                        lfsr_d = w_lfsr_next;
                        led_d  = w_pattern;
                        rcnt_d = 4'd0;
                    end else begin
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
                if (w_goal_met || w_time_out) begin
                    led_d  = 16'hFFFF;
                    fcnt_d = 4'd0;
                    win_d  = w_goal_met;
                end
            end
            c_FINAL: begin
                if (tick_i) begin
                    if (fcnt_q == c_FINAL_LAST) begin
                        led_d  = 16'h0000;
                        fcnt_d = 4'd0;
                    end else begin
                        led_d  = ~led_q;
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
            end
            default: led_d = 16'h0000;
        endcase
    end

    assign led_o       = led_q;
    assign score_o     = score_q;
    assign time_left_o = time_q;
    assign phase_o     = state_q;
    assign win_o       = win_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_round_scheduler
// Purpose  : Self-checking bench for mole_round_scheduler. A game-level model
//            tracks the expected outputs each cycle; directed scenarios pin
//            the model with literal values, then random play follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_round_scheduler;

    localparam int REFRESH = 2;
    localparam int FINALT  = 3;

    logic        clk = 1'b0;
    logic        out_rst = 1'b1;
    logic        start_i = 1'b0, tick_i = 1'b0, key_valid_i = 1'b0;
    logic [7:0]  cfg_time_i = 8'd0, cfg_goal_i = 8'd0;
    logic [3:0]  key_idx_i = 4'd0;
    logic [15:0] led_o;
    logic [7:0]  score_o, time_left_o;
    logic [1:0]  phase_o;
    logic        win_o;

    int checks = 0;
    int failures = 0;

    // Game model
    int          m_phase, m_score, m_time, m_goal, m_win, m_rc, m_fc;
    logic [15:0] m_led, m_lfsr;

    mole_round_scheduler #(.REFRESH_TICKS(REFRESH), .FINAL_TICKS(FINALT),
                           .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .out_rst(out_rst), .start_i(start_i), .tick_i(tick_i),
        .cfg_time_i(cfg_time_i), .cfg_goal_i(cfg_goal_i),
        .key_valid_i(key_valid_i), .key_idx_i(key_idx_i),
        .led_o(led_o), .score_o(score_o), .time_left_o(time_left_o),
        .phase_o(phase_o), .win_o(win_o));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] pattern_of(input logic [15:0] v);
        logic [15:0] top;
        top = v & 16'hFFC0;
        return (top == 16'h0000) ? 16'h8000 : top;
    endfunction

    function automatic int lit_key();
        for (int k = 0; k < 10; k++) if (m_led[15-k]) return k;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_time = 0; m_goal = 0; m_win = 0;
        m_rc = 0; m_fc = 0; m_led = 16'h0; m_lfsr = 16'hACE1;
    endtask

    // One clock edge of game rules applied to the sampled inputs.
    task automatic model_edge(input bit st, input bit tk, input bit kv, input int ki,
                              input int ct, input int cg);
        bit done, won;
        case (m_phase)
            0: begin
                m_led = 16'h0;
                if (st) begin
                    m_time  = (ct == 0) ? 1 : ct;
                    m_goal  = (cg == 0) ? 1 : cg;
                    m_score = 0; m_win = 0; m_rc = 0;
                    m_lfsr  = lfsr_step(m_lfsr);
                    m_led   = pattern_of(m_lfsr);
                    m_phase = 1;
                end
            end
            1: begin
                won  = (m_score == m_goal);
                done = won || (m_time == 0);
                if (kv && ki < 10 && m_led[15-ki]) begin
                    m_led[15-ki] = 1'b0;
                    if (m_score < 99) m_score++;
                end
                if (tk) begin
                    if (m_time > 0) m_time--;
                    m_rc++;
                    if (m_rc == REFRESH) begin
                        m_lfsr = lfsr_step(m_lfsr);
                        m_led  = pattern_of(m_lfsr);
                        m_rc   = 0;
                    end
                end
                if (done) begin
                    m_phase = 2; m_led = 16'hFFFF; m_fc = 0; m_win = won;
                end
            end
            default: begin
                if (tk) begin
                    m_fc++;
                    if (m_fc == FINALT) begin
                        m_phase = 0; m_led = 16'h0; m_fc = 0;
                    end else begin
                        m_led = ~m_led;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("led", int'(led_o), int'(m_led));
        chk("score", int'(score_o), m_score);
        chk("time_left", int'(time_left_o), m_time);
        chk("phase", int'(phase_o), m_phase);
        chk("win", int'(win_o), m_win);
    endtask

    task automatic cyc(input bit st, input bit tk, input bit kv, input int ki);
        @(negedge clk);
        start_i = st; tick_i = tk; key_valid_i = kv; key_idx_i = 4'(ki);
        @(posedge clk);
        model_edge(st, tk, kv, ki, int'(cfg_time_i), int'(cfg_goal_i));
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        start_i = 0; tick_i = 0; key_valid_i = 0; key_idx_i = 0;
        #1 out_rst = 1'b1;
        #1;
        model_reset();
        chk("rst_phase", int'(phase_o), 0);
        chk("rst_led", int'(led_o), 0);
        chk("rst_score", int'(score_o), 0);
        chk("rst_time", int'(time_left_o), 0);
        chk("rst_win", int'(win_o), 0);
        #1 out_rst = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0, 0, 0, 0);
        #1 compare_all();
    endtask

    task automatic drain_final();
        for (int i = 0; i < 8 && m_phase != 0; i++) cyc(0, 1, 0, 0);
    endtask

    initial begin
        int k;
        model_reset();
        do_reset();

        // Start and first pattern
        cfg_time_i = 8'd30; cfg_goal_i = 8'd10;
        cyc(1, 0, 0, 0);
        chk("s1_led", int'(led_o), 16'hE240);
        chk("s1_time", int'(time_left_o), 30);
        chk("s1_phase", int'(phase_o), 1);
        cyc(0, 0, 1, 1);
        chk("s2_led", int'(led_o), 16'hA240);
        chk("s2_score", int'(score_o), 1);
        cyc(0, 0, 1, 1);
        chk("s2_repeat", int'(led_o), 16'hA240);
        cyc(0, 0, 1, 3);
        chk("s2_unlit", int'(score_o), 1);
        cyc(0, 0, 1, 12);
        chk("s2_nondigit", int'(led_o), 16'hA240);
        cyc(1, 0, 0, 0);
        chk("s6_start_run", int'(time_left_o), 30);

        // Reset mid-game, then win with goal 2
        do_reset();
        cfg_goal_i = 8'd2;
        cyc(1, 0, 0, 0);
        chk("s3_led", int'(led_o), 16'hE240);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 2);
        chk("s3_led2", int'(led_o), 16'h4240);
        chk("s3_score", int'(score_o), 2);
        cyc(0, 0, 0, 0);
        chk("s3_phase", int'(phase_o), 2);
        chk("s3_win", int'(win_o), 1);
        chk("s3_flash", int'(led_o), 16'hFFFF);
        cyc(0, 1, 0, 0); chk("s3_f1", int'(led_o), 16'h0000);
        cyc(0, 1, 0, 0); chk("s3_f2", int'(led_o), 16'hFFFF);
        cyc(0, 1, 0, 0); chk("s3_f3", int'(led_o), 16'h0000);
        chk("s3_idle", int'(phase_o), 0);

        // Timeout
        cfg_time_i = 8'd3; cfg_goal_i = 8'd10;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("s4_time0", int'(time_left_o), 0);
        chk("s4_still_run", int'(phase_o), 1);
        cyc(0, 0, 0, 0);
        chk("s4_phase", int'(phase_o), 2);
        chk("s4_lose", int'(win_o), 0);
        drain_final();

        // Final hit coincides with the last tick: win has priority
        cfg_time_i = 8'd1; cfg_goal_i = 8'd1;
        cyc(1, 0, 0, 0);
        k = lit_key();
        cyc(0, 1, 1, k);
        chk("s4_both_time", int'(time_left_o), 0);
        cyc(0, 0, 0, 0);
        chk("s4_prio_win", int'(win_o), 1);
        drain_final();

        // Refresh collides with a hit
        cfg_time_i = 8'd30; cfg_goal_i = 8'd10;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        k = lit_key();
        cyc(0, 1, 1, k);
        chk("s5_score", int'(score_o), 1);
        chk("s5_led", int'(led_o), int'(pattern_of(m_lfsr)));

        // Zero configuration loads as one
        do_reset();
        cfg_time_i = 8'd0; cfg_goal_i = 8'd0;
        cyc(1, 0, 0, 0);
        chk("s6_time1", int'(time_left_o), 1);
        chk("s6_led", int'(led_o), 16'hE240);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("s6_final", int'(phase_o), 2);
        drain_final();

        // Random play
        for (int n = 0; n < 4000; n++) begin
            bit st, tk, kv;
            int ki;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if (m_phase == 0) begin
                    cfg_time_i = 8'($urandom_range(0, 6));
                    cfg_goal_i = 8'($urandom_range(0, 5));
                end
                st = ($urandom_range(0, 7) == 0);
                tk = ($urandom_range(0, 3) == 0);
                kv = ($urandom_range(0, 1) == 0);
                ki = ($urandom_range(0, 1) == 0) ? lit_key() : int'($urandom_range(0, 15));
                cyc(st, tk, kv, ki);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Round controller for the keypad whack-a-LED game. It sequences one game from start to finish. It owns the target LED pattern, the seconds countdown, the score/goal comparison and the end-of-game flashing phase, so the top level only supplies debounced pulses, configuration values and decoded key events. It sits between the settings logic and keyboard decoder (upstream) and the LED bank and seven-segment formatter (downstream).

## Interface
- `REFRESH_TICKS`, default 2: seconds between target-pattern reloads during RUN (legal range 1..15).
- `FINAL_TICKS`, default 3: seconds spent in FINAL before returning to IDLE (legal range 1..15).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value (must be nonzero).
- `clk`, input, 1: system clock.
- `out_rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: one-cycle start pulse.
- `tick`, input, 1: one-cycle pulse, once per second.
- `cfg_time`, input, 8: game length in seconds, binary 0..99.
- `cfg_goal`, input, 8: required hits, binary 0..99.
- `key_valid`, input, 1: one-cycle pulse marking a new key press.
- `key_idx`, input, 4: decoded digit 0..9; values 10..15 mean a non-digit key.
- `led`, output, 16: current target pattern, or the flash pattern while in FINAL.
- `score`, output, 8: hits so far, binary.
- `time_left`, output, 8: seconds remaining, binary.
- `phase`, output, 2: current state (0 = IDLE, 1 = RUN, 2 = FINAL).
- `win`, output, 1: result of the last game; meaningful in FINAL.

## Operation
States: IDLE, RUN, FINAL. Encoding 3 is unreachable and recovers to IDLE on the next edge.

**Reset values**
- phase = IDLE.
- led = 0, score = 0, time_left = 0, win = 0.
- lfsr = LFSR_SEED.
- Refresh counter = 0, final counter = 0.

**LFSR**
- 16-bit Galois LFSR, right shift, mask 16'hB400.
- Step rule: next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
- It steps only on a load event: start accepted, or a refresh.
- It is never reseeded except by `out_rst`.
- Pattern derived from the stepped value: {next[15:6], 6'b0}. If next[15:6] is zero, the pattern is 16'h8000.

**Key to LED mapping**
- Key k (0..9) targets `led` bit 15-k.
- Bits 5..0 are never targets.

**IDLE**
- `led` = 0. `score`, `time_left` and `win` hold their last values.
- On `start`:
  - time_left ← max(cfg_time, 1).
  - Latch goal ← max(cfg_goal, 1).
  - score ← 0, win ← 0.
  - Step the LFSR and load the new pattern into `led`.
  - Refresh counter ← 0; move to RUN.

**RUN**
- Hit: `key_valid` with key_idx ≤ 9 and led[15-key_idx] = 1.
  - Clear that bit.
  - score ← score + 1, saturating at 99.
- Non-hits are ignored: a key on an unlit LED, key_idx > 9, or a repeated key.
- On `tick`:
  - time_left ← time_left − 1.
  - Refresh counter increments.
  - When the counter reaches REFRESH_TICKS: step the LFSR, load the new pattern, counter ← 0.
- A refresh load overrides any hit-clear in the same cycle. The hit still scores if it was evaluated against the pre-refresh `led`.
- Exit conditions, evaluated on the post-update values:
  - score = goal → FINAL with win = 1.
  - Otherwise time_left = 0 → FINAL with win = 0.
  - If both occur in the same cycle, win takes priority.
- `start` in RUN is ignored.

**FINAL**
- On entry: `led` = 16'hFFFF, final counter ← 0.
- Each `tick`: invert `led` and increment the counter.
- When the counter reaches FINAL_TICKS: move to IDLE with `led` = 0.
- `start` and keys are ignored. `score`, `time_left` and `win` are frozen.

## Timing
- All outputs are registered, with no combinational path from input to output.
- `start` sampled at edge N:
  - phase = RUN after edge N.
  - `led`, `time_left` and `score` are valid after edge N.
- A hit sampled at edge N updates the `led` bit and `score` after edge N.
- A terminal condition created at edge N puts phase = FINAL (and `led` = FFFF) after edge N+1. Hits and ticks in the intervening cycle are still processed as RUN.
- FINAL lasts exactly FINAL_TICKS tick pulses.
- A `tick` and a `key_valid` in the same cycle are both applied.
- `out_rst` asserted at any time forces the reset values immediately, independent of `clk`.

## Test plan
1. **Reset, start, first pattern.** Reset, cfg_time = 30, cfg_goal = 10, pulse `start` → after one edge: phase = 1, time_left = 30, score = 0, `led` = 16'hE240.
2. **Hit versus miss.** From scenario 1: key 1 → led = 16'hA240 and score = 1. Key 1 again → no change. Key 3 (unlit) → no change. key_idx = 12 → no change.
3. **Win.** cfg_goal = 2: hit keys 0 and 2 → one edge after the second hit phase = 2, win = 1, led = FFFF. The next three ticks give led = 0000, FFFF, 0000, then phase = 0 and led = 0.
4. **Timeout and win priority.** cfg_time = 3 with no hits → after 3 ticks: time_left = 0, then phase = 2, win = 0. Separately, align the final needed hit with the tick that zeroes time_left → win = 1.
5. **Refresh collision.** With REFRESH_TICKS = 2, issue a hit in the same cycle as the second tick → score increments and `led` equals the next LFSR pattern with no bit cleared.
6. **Zero configuration, start during RUN, reset mid-game.** cfg_time = 0 and cfg_goal = 0 load as 1 and 1. A `start` during RUN is ignored. `out_rst` asserted mid-RUN → immediately phase = 0, led = 0, score = 0, time_left = 0, lfsr = ACE1 (the next start again gives E240).
